// File: rtl/flag_unit.sv
`default_nettype none
// ============================================================================
//  Module      : flag_unit
//  Description : Processor-style flag register with bit/op updates, masked
//                ALU flag merge, a LIFO save/restore stack and sticky
//                push-overflow / pop-underflow error bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module flag_unit #(
   parameter int FLAG_WIDTH  = 4,   // bit0 C, bit1 V, bit2 Z, bit3 N, above: general purpose
   parameter int STACK_DEPTH = 4,   // power of two, >= 2
   parameter int SEL_W       = 2    // clog2(FLAG_WIDTH)
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          op_valid_i,
   input  logic [2:0]                    op_i,
   input  logic [SEL_W-1:0]              flag_sel_i,
   input  logic [FLAG_WIDTH-1:0]         load_data_i,
   input  logic                          alu_we_i,
   input  logic [FLAG_WIDTH-1:0]         alu_flags_i,
   input  logic [FLAG_WIDTH-1:0]         alu_mask_i,
   input  logic                          push_i,
   input  logic                          pop_i,
   input  logic                          err_clr_i,
   output logic [FLAG_WIDTH-1:0]         flags_o,
   output logic [$clog2(STACK_DEPTH):0]  depth_o,
   output logic                          stack_empty_o,
   output logic                          stack_full_o,
   output logic                          err_ovf_o,
   output logic                          err_unf_o
);

   localparam int PTR_W   = $clog2(STACK_DEPTH);
   localparam int DEPTH_W = PTR_W + 1;

   typedef enum logic [2:0] {
      OP_NOP     = 3'd0,
      OP_CLR     = 3'd1,
      OP_SET     = 3'd2,
      OP_TGL     = 3'd3,
      OP_CLR_ALL = 3'd4,
      OP_SET_ALL = 3'd5,
      OP_LOAD    = 3'd6,
      OP_RSVD    = 3'd7
   } op_e;

   // Architectural state
   logic [FLAG_WIDTH-1:0] flags_q,   flags_d;
   logic [DEPTH_W-1:0]    depth_q,   depth_d;
   logic                  err_ovf_q, err_ovf_d;
   logic                  err_unf_q, err_unf_d;

   // Save stack storage; entries at or above depth_q are don't-care
   logic [FLAG_WIDTH-1:0] stack_q [STACK_DEPTH];

   // Combinational helpers
   logic                  w_sel_ok;
   logic [FLAG_WIDTH-1:0] w_bit;
   logic [FLAG_WIDTH-1:0] w_op_res;
   logic [FLAG_WIDTH-1:0] w_merged;
   logic                  w_empty;
   logic                  w_full;
   logic [DEPTH_W-1:0]    w_depth_m1;
   logic [PTR_W-1:0]      w_top_idx;
   logic [PTR_W-1:0]      w_push_idx;
   logic [FLAG_WIDTH-1:0] w_top;
   logic                  w_wr_en;
   logic [PTR_W-1:0]      w_wr_idx;
   logic                  w_new_ovf;
   logic                  w_new_unf;

   // Bit-select ops only act on indices that name a real flag bit
   assign w_sel_ok = ({1'b0, flag_sel_i} < (SEL_W + 1)'(FLAG_WIDTH));
   assign w_bit    = FLAG_WIDTH'(1) << flag_sel_i;

   assign w_empty    = (depth_q == '0);
   assign w_full     = (depth_q == DEPTH_W'(STACK_DEPTH));
   assign w_depth_m1 = depth_q - DEPTH_W'(1);
   // Low pointer bits are exact whenever they are used: push only when not
   // full, pop/swap only when not empty.
   assign w_top_idx  = w_depth_m1[PTR_W-1:0];
   assign w_push_idx = depth_q[PTR_W-1:0];
   assign w_top      = stack_q[w_top_idx];

   // Flag-manipulation op result, computed from the current flag value
   always_comb begin
      w_op_res = flags_q;
      if (op_valid_i) begin
         case (op_e'(op_i))
            OP_CLR:     if (w_sel_ok) w_op_res = flags_q & ~w_bit;
            OP_SET:     if (w_sel_ok) w_op_res = flags_q |  w_bit;
            OP_TGL:     if (w_sel_ok) w_op_res = flags_q ^  w_bit;
            OP_CLR_ALL: w_op_res = '0;
            OP_SET_ALL: w_op_res = '1;
            OP_LOAD:    w_op_res = load_data_i;
            default:    w_op_res = flags_q;
         endcase
      end
   end

   // ALU merge overrides the op result on the bits selected by the mask
   assign w_merged = alu_we_i ? ((w_op_res & ~alu_mask_i) | (alu_flags_i & alu_mask_i))
                              : w_op_res;

   // Stack control: decides next flags, depth, stack write and new errors
   always_comb begin
      flags_d   = w_merged;
      depth_d   = depth_q;
      w_wr_en   = 1'b0;
      w_wr_idx  = w_push_idx;
      w_new_ovf = 1'b0;
      w_new_unf = 1'b0;

      if (push_i && pop_i) begin
         if (!w_empty) begin
            // Swap current flags with the stack top; op/ALU are discarded
            flags_d  = w_top;
            w_wr_en  = 1'b1;
            w_wr_idx = w_top_idx;
         end else begin
            // Nothing to swap with: behaves as an underflowing pop
            w_new_unf = 1'b1;
         end
      end else if (push_i) begin
         if (!w_full) begin
            // Save the pre-update flags; op/ALU still update flags
            w_wr_en = 1'b1;
            depth_d = depth_q + DEPTH_W'(1);
         end else begin
            w_new_ovf = 1'b1;
         end
      end else if (pop_i) begin
         if (!w_empty) begin
            flags_d = w_top;
            depth_d = w_depth_m1;
         end else begin
            w_new_unf = 1'b1;
         end
      end

      // Clearing takes priority over an error raised in the same cycle
      err_ovf_d = err_clr_i ? 1'b0 : (err_ovf_q | w_new_ovf);
      err_unf_d = err_clr_i ? 1'b0 : (err_unf_q | w_new_unf);
   end

   // Flag, depth and error registers with asynchronous reset
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         flags_q   <= '0;
         depth_q   <= '0;
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;
      end else begin
         flags_q   <= flags_d;
         depth_q   <= depth_d;
         err_ovf_q <= err_ovf_d;
         err_unf_q <= err_unf_d;
      end
   end

   // Stack storage write port; contents are invalidated by depth reset only
   always_ff @(posedge clk_i) begin
      if (w_wr_en) begin
         stack_q[w_wr_idx] <= flags_q;
      end
   end

   assign flags_o       = flags_q;
   assign depth_o       = depth_q;
   assign stack_empty_o = w_empty;
   assign stack_full_o  = w_full;
   assign err_ovf_o     = err_ovf_q;
   assign err_unf_o     = err_unf_q;

endmodule
`default_nettype wire

// File: tb/tb_flag_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flag_unit
//  Description : Self-checking bench for flag_unit: directed scenarios plus
//                randomized traffic against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flag_unit;

   localparam int FW = 4;
   localparam int SD = 4;
   localparam int SW = 2;
   localparam int DW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          op_valid;
   logic [2:0]    op;
   logic [SW-1:0] flag_sel;
   logic [FW-1:0] load_data;
   logic          alu_we;
   logic [FW-1:0] alu_flags;
   logic [FW-1:0] alu_mask;
   logic          push;
   logic          pop;
   logic          err_clr;
   logic [FW-1:0] flags;
   logic [DW-1:0] depth;
   logic          stack_empty;
   logic          stack_full;
   logic          err_ovf;
   logic          err_unf;

   // Reference model state
   logic [FW-1:0] m_flags;
   logic [FW-1:0] m_stk[$];
   logic          m_ovf;
   logic          m_unf;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   flag_unit #(.FLAG_WIDTH(FW), .STACK_DEPTH(SD), .SEL_W(SW)) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .op_valid_i   (op_valid),
      .op_i         (op),
      .flag_sel_i   (flag_sel),
      .load_data_i  (load_data),
      .alu_we_i     (alu_we),
      .alu_flags_i  (alu_flags),
      .alu_mask_i   (alu_mask),
      .push_i       (push),
      .pop_i        (pop),
      .err_clr_i    (err_clr),
      .flags_o      (flags),
      .depth_o      (depth),
      .stack_empty_o(stack_empty),
      .stack_full_o (stack_full),
      .err_ovf_o    (err_ovf),
      .err_unf_o    (err_unf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string where);
      check({where, ".flags"}, 32'(flags),       32'(m_flags));
      check({where, ".depth"}, 32'(depth),       32'(m_stk.size()));
      check({where, ".empty"}, 32'(stack_empty), 32'(m_stk.size() == 0));
      check({where, ".full"},  32'(stack_full),  32'(m_stk.size() == SD));
      check({where, ".ovf"},   32'(err_ovf),     32'(m_ovf));
      check({where, ".unf"},   32'(err_unf),     32'(m_unf));
   endtask

   task automatic model_reset();
      m_flags = '0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // Next state from the rules, applied to the inputs of the coming edge
   task automatic model_step();
      logic [FW-1:0] fop, nxt;
      bit new_ovf = 0, new_unf = 0;
      int d = m_stk.size();
      int s = int'(flag_sel);
      fop = m_flags;
      if (op_valid) begin
         case (op)
            3'd1: if (s < FW) fop[s] = 1'b0;
            3'd2: if (s < FW) fop[s] = 1'b1;
            3'd3: if (s < FW) fop[s] = ~fop[s];
            3'd4: fop = '0;
            3'd5: fop = '1;
            3'd6: fop = load_data;
            default: ;
         endcase
      end
      nxt = fop;
      for (int b = 0; b < FW; b++)
         if (alu_we && alu_mask[b]) nxt[b] = alu_flags[b];
      if (push && pop) begin
         if (d > 0) begin
            nxt = m_stk.pop_back();
            m_stk.push_back(m_flags);
         end else new_unf = 1;
      end else if (push) begin
         if (d < SD) m_stk.push_back(m_flags);
         else new_ovf = 1;
      end else if (pop) begin
         if (d > 0) nxt = m_stk.pop_back();
         else new_unf = 1;
      end
      m_flags = nxt;
      m_ovf = err_clr ? 1'b0 : (m_ovf | new_ovf);
      m_unf = err_clr ? 1'b0 : (m_unf | new_unf);
   endtask

   task automatic idle();
      op_valid = 0; op = 3'd0; flag_sel = '0; load_data = '0;
      alu_we = 0; alu_flags = '0; alu_mask = '0;
      push = 0; pop = 0; err_clr = 0;
   endtask

   task automatic set_op(input logic [2:0] o, input logic [SW-1:0] s, input logic [FW-1:0] ld);
      idle();
      op_valid = 1; op = o; flag_sel = s; load_data = ld;
   endtask

   task automatic tick(input string where);
      model_step();
      @(posedge clk);
      #1;
      check_all(where);
   endtask

   initial begin
      idle();
      reset = 1'b1;
      model_reset();
      #3;
      check_all("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Bit ops
      set_op(3'd2, 2'd0, '0); tick("set0");
      set_op(3'd2, 2'd2, '0); tick("set2");
      check("set_pattern", 32'(flags), 32'h5);
      set_op(3'd3, 2'd0, '0); tick("tgl0");
      check("tgl_pattern", 32'(flags), 32'h4);
      set_op(3'd4, 2'd0, '0); tick("clr_all");
      check("clr_all_pattern", 32'(flags), 32'h0);

      // ALU merge over a CLR
      set_op(3'd5, 2'd0, '0); tick("set_all");
      set_op(3'd1, 2'd3, '0);
      alu_we = 1; alu_mask = 4'b0011; alu_flags = 4'b0010;
      tick("alu_merge");
      check("alu_merge_pattern", 32'(flags), 32'h6);

      // Fill the stack with 1,2,3,4
      set_op(3'd6, 2'd0, 4'd1); tick("load1");
      set_op(3'd6, 2'd0, 4'd2); push = 1; tick("push1");
      set_op(3'd6, 2'd0, 4'd3); push = 1; tick("push2");
      set_op(3'd6, 2'd0, 4'd4); push = 1; tick("push3");
      set_op(3'd6, 2'd0, 4'd0); push = 1; tick("push4");
      check("full_flag", 32'(stack_full), 32'h1);
      idle(); push = 1; tick("push_ovf");
      check("ovf_flag", 32'(err_ovf), 32'h1);
      check("ovf_depth", 32'(depth), 32'h4);
      for (int i = 4; i >= 1; i--) begin
         idle(); pop = 1; tick("pop");
         check("pop_order", 32'(flags), 32'(i));
      end
      check("empty_flag", 32'(stack_empty), 32'h1);

      // Underflow and clear priority
      idle(); pop = 1; tick("pop_unf");
      check("unf_flag", 32'(err_unf), 32'h1);
      check("unf_flags_kept", 32'(flags), 32'h1);
      idle(); pop = 1; err_clr = 1; tick("clr_wins");
      check("clr_wins_unf", 32'(err_unf), 32'h0);

      // Swap
      set_op(3'd6, 2'd0, 4'b0101); tick("load5");
      set_op(3'd6, 2'd0, 4'b1010); push = 1; tick("push5");
      idle(); push = 1; pop = 1; tick("swap");
      check("swap_flags", 32'(flags), 32'h5);
      check("swap_depth", 32'(depth), 32'h1);
      idle(); pop = 1; tick("pop_after_swap");
      check("swap_top", 32'(flags), 32'hA);

      // Push+pop on empty stack with an op: underflow, op applies
      set_op(3'd5, 2'd0, '0); push = 1; pop = 1; tick("swap_empty");
      check("swap_empty_flags", 32'(flags), 32'hF);

      // Asynchronous reset mid-sequence
      idle(); err_clr = 1; tick("clr_errs");
      idle(); push = 1; tick("fill_a");
      idle(); push = 1; tick("fill_b");
      set_op(3'd5, 2'd0, '0); push = 1; tick("fill_c");
      check("pre_reset_depth", 32'(depth), 32'h3);
      idle();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("async_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      set_op(3'd2, 2'd1, '0); tick("post_reset");

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         op_valid  = 1'($urandom);
         op        = 3'($urandom);
         flag_sel  = SW'($urandom);
         load_data = FW'($urandom);
         alu_we    = ($urandom_range(0, 3) == 0);
         alu_flags = FW'($urandom);
         alu_mask  = FW'($urandom);
         push      = ($urandom_range(0, 2) == 0);
         pop       = ($urandom_range(0, 2) == 0);
         err_clr   = ($urandom_range(0, 7) == 0);
         tick("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/flag_unit.md
FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 Parameter FLAG_WIDTH, default 4, SHALL set the number of flag bits; bit 0 carry, bit 1 overflow, bit 2 zero, bit 3 negative, higher bits general-purpose.
REQ-002 Parameter STACK_DEPTH, default 4, SHALL set the flag save-stack entries, power of two, at least 2.
REQ-003 Parameter SEL_W, default 2, SHALL equal clog2(FLAG_WIDTH).
REQ-004 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 op_valid  in  1  op is applied this cycle.
REQ-007 op  in  3  0 NOP, 1 CLR bit, 2 SET bit, 3 TGL bit, 4 CLR_ALL, 5 SET_ALL, 6 LOAD, 7 reserved (acts as NOP).
REQ-008 flag_sel  in  SEL_W  bit index for CLR, SET and TGL.
REQ-009 load_data  in  FLAG_WIDTH  value for LOAD.
REQ-010 alu_we  in  1  merge ALU result flags this cycle.
REQ-011 alu_flags  in  FLAG_WIDTH  ALU-produced flags.
REQ-012 alu_mask  in  FLAG_WIDTH  1 = bit is written by the ALU merge.
REQ-013 push  in  1  save current flags to the stack.
REQ-014 pop  in  1  restore flags from the stack top.
REQ-015 err_clr  in  1  clears the sticky error bits.
REQ-016 flags  out  FLAG_WIDTH  registered flag state.
REQ-017 depth  out  clog2(STACK_DEPTH)+1  number of occupied stack entries.
REQ-018 stack_empty / stack_full  out  1 each  depth==0 / depth==STACK_DEPTH.
REQ-019 err_ovf / err_unf  out  1 each  sticky push-overflow / pop-underflow.

Function
REQ-020 flags SHALL be registered; every update SHALL be visible on flags exactly one cycle after the inputs are sampled.
REQ-021 Op result f_op SHALL be: CLR flags & ~(1<<sel); SET flags | (1<<sel); TGL flags ^ (1<<sel); CLR_ALL 0; SET_ALL all ones; LOAD load_data; otherwise flags; with op_valid=0, f_op = flags.
REQ-022 flag_sel >= FLAG_WIDTH SHALL make CLR, SET and TGL act as NOP.
REQ-023 With alu_we=1, next = (f_op & ~alu_mask) | (alu_flags & alu_mask); with alu_we=0, next = f_op.
REQ-024 push alone, not full: stack[depth] <= current flags (pre-update value), depth+1; the op and ALU merge still apply to flags in the same cycle.
REQ-025 pop alone, not empty: flags <= stack[depth-1], depth-1; pop SHALL override op and ALU merge that cycle.
REQ-026 push and pop together, not empty: swap, stack top <= current flags, flags <= old stack top, depth unchanged; op and ALU merge ignored.
REQ-027 push and pop together, empty: treated as underflow; flags <= ALU/op result; depth unchanged.
REQ-028 push when full: ignored, depth unchanged, err_ovf <= 1; op and ALU merge still apply.
REQ-029 pop when empty: ignored, err_unf <= 1; op and ALU merge apply.
REQ-030 err_ovf and err_unf SHALL stay set until err_clr=1; err_clr SHALL win over a same-cycle new error.
REQ-031 The stack SHALL be LIFO with no wrap-around; entries above depth are don't-care.

Reset
REQ-032 reset=1 SHALL immediately, without waiting for clk, force flags=0, depth=0, stack_empty=1, stack_full=0, err_ovf=0, err_unf=0.
REQ-033 Reset asserted mid-sequence SHALL discard all stack contents; stack RAM need not be cleared.
REQ-034 After reset release, the first rising clk edge SHALL process inputs normally.

Verification
REQ-035 Reset, then SET sel=0 and SET sel=2 -> flags=4'b0101; TGL sel=0 -> 4'b0100; CLR_ALL -> 4'b0000.
REQ-036 flags=4'b1111, alu_we=1, alu_mask=4'b0011, alu_flags=4'b0010, op CLR sel=3 -> flags=4'b0110 next cycle.
REQ-037 Four pushes of 1,2,3,4 (STACK_DEPTH=4) -> stack_full=1; fifth push -> err_ovf=1, depth=4; four pops -> flags 4,3,2,1 in order, stack_empty=1.
REQ-038 Pop when empty -> err_unf=1, flags unchanged; err_clr with a simultaneous empty pop -> err_unf=0.
REQ-039 flags=4'b1010, stack top 4'b0101, push+pop -> flags=4'b0101, top=4'b1010, depth unchanged.
REQ-040 Assert reset asynchronously between clock edges with depth=3, flags=4'b1111 -> flags=0, depth=0 before the next edge.
